stopwatch_button_ctrl: RTL and testbench
========================================

// Module: stopwatch_button_ctrl
// PURPOSE
//  Front-end stage feeding the stopwatch top level: turns two raw, bouncing push
//  buttons into the clean 'run' level and 'clear' pulse that drive the seconds
//  counter. Each button is synchronised, debounced and edge-detected; a 3-state
//  FSM (IDLE/RUNNING/PAUSED) owns start/stop/clear policy.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles an input must stay at its new level before it is accepted (10 ms @ 50 MHz); >=2
//  BTN_ACTIVE_LOW   0       1: raw buttons read 0 when pressed; inverted at input
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  btn_startstop_raw in 1 asynchronous raw start/stop button
//  btn_clear_raw in   1  asynchronous raw clear button
//  run          out  1  level: 1 = counter counts (to seconds counter 'start')
//  clear        out  1  one-cycle pulse: zero the time digits
//  state        out  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED (11 unused)
// BEHAVIOUR
//  One clock, synchronous active-high reset. No combinational input-to-output path; all outputs registered.
//  Reset: run=0, clear=0, state=IDLE; sync FFs and debounced levels = released;
//   debounce counters = 0. Reset mid-debounce or mid-run discards all progress.
//  Input path per button: optional inversion -> 2-FF synchroniser -> debouncer.
//  Debouncer: counter width $clog2(DEBOUNCE_CYCLES). While synced != stable,
//   count up; when count reaches DEBOUNCE_CYCLES-1 and still differs, stable<=synced,
//   count<=0. Any cycle with synced == stable clears count (glitch rejected).
//  Press event: stable 0->1 gives a one-cycle 'press' strobe; release gives none.
//   Holding a button yields exactly one press.
//  Latency: raw edge -> press strobe = 2 (sync) + DEBOUNCE_CYCLES cycles;
//   press strobe -> run/clear/state update = 1 cycle.
//  FSM (ss = start/stop press, cl = clear press), evaluated each cycle:
//   IDLE:    ss -> RUNNING (run=1). cl -> stay IDLE, clear pulse. ss&cl -> clear
//            wins: clear pulse, stay IDLE.
//   RUNNING: ss -> PAUSED (run=0). cl ignored (no pulse). ss&cl -> PAUSED, no pulse.
//   PAUSED:  ss -> RUNNING (run=1). cl -> IDLE, clear pulse. ss&cl -> clear wins:
//            IDLE, clear pulse, run stays 0.
//   Illegal state 11 -> IDLE next cycle, run=0, clear=0.
//  run == (state==RUNNING) at all times; clear is high for exactly 1 cycle per
//   accepted clear and never high while run=1.
//  Button held through reset release: treated as fresh press after full debounce.
// TESTING (bench uses DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=0)
//  1 Reset then idle 20 cycles -> run=0, clear=0, state=00 throughout.
//  2 Clean startstop press held 10 cycles -> run rises exactly 2+4+1=7 cycles
//    after raw edge; state=01; single transition only.
//  3 Bounce: startstop toggles 1,0,1,0 every cycle then settles 1 -> one press,
//    run=1 once; 3-cycle pulse alone -> no change.
//  4 RUNNING, press clear -> no clear pulse, run stays 1; press startstop ->
//    state=10; press clear -> one 1-cycle clear pulse, state=00.
//  5 PAUSED, both buttons pressed same cycle -> clear pulse, state=00, run=0.
//  6 Assert reset while RUNNING and mid-debounce -> next cycle run=0, state=00,
//    no stale press strobe after reset release.

Source files
------------

// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch button front end: synchronises and debounces the start/stop and clear
// buttons, then runs the IDLE/RUNNING/PAUSED policy that drives 'run' and 'clear'.

module stopwatch_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_in;
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    assign btn_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            press <= 1'b0;
            // A single cycle back at the accepted level restarts the qualification window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module stopwatch_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_startstop_raw,
    input  logic       btn_clear_raw,
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);
    // state   | meaning
    // IDLE    | time zeroed, counter stopped
    // RUNNING | counter counting, clear ignored
    // PAUSED  | counter held, clear returns to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    state_t state_q;
    logic   ss_press;
    logic   cl_press;

    stopwatch_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (BTN_ACTIVE_LOW != 0)
    ) u_db_startstop (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_startstop_raw),
        .press  (ss_press)
    );

    stopwatch_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (BTN_ACTIVE_LOW != 0)
    ) u_db_clear (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_clear_raw),
        .press  (cl_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            run     <= 1'b0;
            clear   <= 1'b0;
        end else begin
            clear <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cl_press) begin
                        clear <= 1'b1;
                    end else if (ss_press) begin
                        state_q <= RUNNING;
                        run     <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (ss_press) begin
                        state_q <= PAUSED;
                        run     <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (cl_press) begin
                        state_q <= IDLE;
                        clear   <= 1'b1;
                    end else if (ss_press) begin
                        state_q <= RUNNING;
                        run     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run     <= 1'b0;
                    clear   <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl with a 4-cycle debounce window.

module tb_stopwatch_button_ctrl;
    logic       clk;
    logic       reset;
    logic       btn_startstop_raw;
    logic       btn_clear_raw;
    logic       run;
    logic       clear;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_startstop_raw(btn_startstop_raw),
        .btn_clear_raw    (btn_clear_raw),
        .run              (run),
        .clear            (clear),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_startstop_raw = 1'b0;
        btn_clear_raw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Press the given buttons for 8 cycles, release for 8; report what was observed.
    task automatic press_btn(input bit ss, input bit cl,
                             output int clr_cnt, output int run_cnt, output int both_cnt);
        clr_cnt = 0;
        run_cnt = 0;
        both_cnt = 0;
        btn_startstop_raw = ss;
        btn_clear_raw = cl;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                btn_startstop_raw = 1'b0;
                btn_clear_raw = 1'b0;
            end
            tick();
            if (clear === 1'b1) clr_cnt++;
            if (run === 1'b1) run_cnt++;
            if (clear === 1'b1 && run === 1'b1) both_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_startstop_raw = 1'b0;
        btn_clear_raw = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({run, clear, state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got run/clear/state=%b required 0000", {run, clear, state});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({run, clear, state} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_after_reset cycle %0d: got %b required 0000", i, {run, clear, state});
            end
        end
    endtask

    task automatic test_clean_press();
        int transitions;
        logic [1:0] prev;
        do_reset();
        transitions = 0;
        prev = state;
        btn_startstop_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (run !== (i >= 7) || state !== ((i >= 7) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL clean_press_latency cycle %0d: got run=%b state=%b required run=%b state=%b",
                         i, run, state, (i >= 7), ((i >= 7) ? 2'b01 : 2'b00));
            end
            if (state !== prev) transitions++;
            prev = state;
        end
        btn_startstop_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== prev) transitions++;
            prev = state;
        end
        n_checks++;
        if (transitions !== 1 || state !== 2'b01 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_press_single: got transitions=%0d state=%b run=%b required 1 01 1",
                     transitions, state, run);
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic prev_run;
        logic [3:0] pattern;
        int ever_run;
        do_reset();
        rises = 0;
        prev_run = run;
        pattern = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            btn_startstop_raw = pattern[i];
            tick();
            if (run === 1'b1 && prev_run !== 1'b1) rises++;
            prev_run = run;
        end
        btn_startstop_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (run === 1'b1 && prev_run !== 1'b1) rises++;
            prev_run = run;
        end
        btn_startstop_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (run === 1'b1 && prev_run !== 1'b1) rises++;
            prev_run = run;
        end
        n_checks++;
        if (rises !== 1 || run !== 1'b1 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_one_press: got rises=%0d run=%b state=%b required 1 1 01", rises, run, state);
        end

        do_reset();
        ever_run = 0;
        btn_startstop_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_startstop_raw = 1'b0;
            tick();
            if (run !== 1'b0 || state !== 2'b00) ever_run++;
        end
        n_checks++;
        if (ever_run !== 0) begin
            n_fail++;
            $display("FAIL short_pulse_rejected: got %0d cycles not idle required 0", ever_run);
        end
    endtask

    task automatic test_running_clear();
        int clr, runh, both;
        do_reset();
        press_btn(1'b1, 1'b0, clr, runh, both);
        press_btn(1'b0, 1'b1, clr, runh, both);
        n_checks++;
        if (clr !== 0 || runh !== 16 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL running_clear_ignored: got clr=%0d runh=%0d state=%b required 0 16 01", clr, runh, state);
        end
        press_btn(1'b1, 1'b0, clr, runh, both);
        n_checks++;
        if (runh !== 6 || state !== 2'b10 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL running_to_paused: got runh=%0d state=%b run=%b required 6 10 0", runh, state, run);
        end
        press_btn(1'b0, 1'b1, clr, runh, both);
        n_checks++;
        if (clr !== 1 || state !== 2'b00 || runh !== 0 || both !== 0) begin
            n_fail++;
            $display("FAIL paused_clear: got clr=%0d state=%b runh=%0d both=%0d required 1 00 0 0",
                     clr, state, runh, both);
        end
    endtask

    task automatic test_both();
        int clr, runh, both;
        do_reset();
        press_btn(1'b1, 1'b0, clr, runh, both);
        press_btn(1'b1, 1'b0, clr, runh, both);
        n_checks++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL reach_paused: got state=%b required 10", state);
        end
        press_btn(1'b1, 1'b1, clr, runh, both);
        n_checks++;
        if (clr !== 1 || state !== 2'b00 || runh !== 0) begin
            n_fail++;
            $display("FAIL paused_both: got clr=%0d state=%b runh=%0d required 1 00 0", clr, state, runh);
        end
        press_btn(1'b1, 1'b1, clr, runh, both);
        n_checks++;
        if (clr !== 1 || state !== 2'b00 || runh !== 0) begin
            n_fail++;
            $display("FAIL idle_both: got clr=%0d state=%b runh=%0d required 1 00 0", clr, state, runh);
        end
        press_btn(1'b0, 1'b1, clr, runh, both);
        n_checks++;
        if (clr !== 1 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_clear: got clr=%0d state=%b required 1 00", clr, state);
        end
    endtask

    task automatic test_reset_mid();
        int clr, runh, both, stale;
        do_reset();
        press_btn(1'b1, 1'b0, clr, runh, both);
        n_checks++;
        if (run !== 1'b1 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL reach_running: got run=%b state=%b required 1 01", run, state);
        end
        btn_startstop_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({run, clear, state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b required 0000", {run, clear, state});
        end
        btn_startstop_raw = 1'b0;
        tick();
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ({run, clear, state} !== 4'b0000) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL no_stale_press: got %0d non-idle cycles required 0", stale);
        end

        btn_startstop_raw = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (run !== (i >= 7)) begin
                n_fail++;
                $display("FAIL held_through_reset cycle %0d: got run=%b required %b", i, run, (i >= 7));
            end
        end
        btn_startstop_raw = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn_startstop_raw = 1'b0;
        btn_clear_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_running_clear();
        test_both();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
